// File: rtl/qpe_pkg.sv
// Shared types and constants for the QPE gate array: coefficient map, lane
// packing offsets, control states and the complex word.
package qpe_pkg;

  localparam int W_DEF    = 18;
  localparam int FRAC_DEF = 16;

  typedef enum logic [2:0] {
    CA_U00_RE = 3'd0,
    CA_U00_IM = 3'd1,
    CA_U01_RE = 3'd2,
    CA_U01_IM = 3'd3,
    CA_U10_RE = 3'd4,
    CA_U10_IM = 3'd5,
    CA_U11_RE = 3'd6,
    CA_U11_IM = 3'd7
  } coef_addr_e;

  // Coefficient slots holding 1.0 in the identity gate (u00_re, u11_re).
  localparam logic [7:0] IDENT_ONES = 8'b0100_0001;

  // Word offsets inside one lane, in units of W bits.
  localparam int OFS_PSI0_RE = 0;
  localparam int OFS_PSI0_IM = 1;
  localparam int OFS_PSI1_RE = 2;
  localparam int OFS_PSI1_IM = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [W_DEF-1:0] im;
    logic signed [W_DEF-1:0] re;
  } cplx_t;

endpackage

// File: rtl/qpe_lane.sv
// One processing element: 2x2 complex gate on an amplitude pair through
// input, multiply, sum and round/saturate stages, all gated by en_i.
module qpe_lane
  import qpe_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [4*W-1:0] psi_i,
  input  logic [8*W-1:0] coef_i,
  output logic [4*W-1:0] psi_o,
  output logic           sat_o
);

  localparam int SW = 2*W + 2;
  localparam int PSI_WORD [4] = '{OFS_PSI0_RE, OFS_PSI0_IM, OFS_PSI1_RE, OFS_PSI1_IM};
  localparam logic signed [SW-1:0] HALF = SW'(2**(FRAC-1));
  localparam logic signed [SW-1:0] MAXV = SW'(2**(W-1) - 1);
  localparam logic signed [SW-1:0] MINV = -SW'(2**(W-1));

  logic        [4*W-1:0] in_q;
  logic signed [2*W-1:0] prod_q [16];
  logic signed [SW-1:0]  sum_q  [4];
  logic        [4*W-1:0] out_q, out_d;

  // prod index = row*8 + col*4 + coef_part*2 + psi_part  (part: 0=re, 1=im)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q  <= '0;
      out_q <= '0;
      for (int i = 0; i < 16; i++) prod_q[i] <= '0;
      for (int i = 0; i < 4; i++) sum_q[i] <= '0;
    end else if (en_i) begin
      in_q <= psi_i;
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++)
          for (int cp = 0; cp < 2; cp++)
            for (int pp = 0; pp < 2; pp++)
              prod_q[j*8 + c*4 + cp*2 + pp] <=
                (2*W)'($signed(coef_i[(j*4 + c*2 + cp)*W +: W])) *
                (2*W)'($signed(in_q[PSI_WORD[c*2 + pp]*W +: W]));
      for (int j = 0; j < 2; j++) begin
        sum_q[2*j]   <= SW'(prod_q[j*8+0]) - SW'(prod_q[j*8+3])
                      + SW'(prod_q[j*8+4]) - SW'(prod_q[j*8+7]);
        sum_q[2*j+1] <= SW'(prod_q[j*8+1]) + SW'(prod_q[j*8+2])
                      + SW'(prod_q[j*8+5]) + SW'(prod_q[j*8+6]);
      end
      out_q <= out_d;
    end
  end

  always_comb begin
    logic signed [SW-1:0] rnd;
    rnd   = '0;
    out_d = '0;
    sat_o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rnd = (sum_q[k] + HALF) >>> FRAC;
      if (rnd > MAXV) begin
        out_d[k*W +: W] = MAXV[W-1:0];
        sat_o = 1'b1;
      end else if (rnd < MINV) begin
        out_d[k*W +: W] = MINV[W-1:0];
        sat_o = 1'b1;
      end else begin
        out_d[k*W +: W] = rnd[W-1:0];
      end
    end
  end

  assign psi_o = out_q;

endmodule

// File: rtl/qpe_gate_array.sv
// N_PES-lane gate array with valid/ready flow control, shadow/active gate
// registers swapped only after the pipeline drains, and sticky saturation.
module qpe_gate_array
  import qpe_pkg::*;
#(
  parameter int N_PES = 4,
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N_PES*4*W-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N_PES*4*W-1:0] m_data,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic [W-1:0]         coef_wdata,
  input  logic                 coef_commit,
  output logic                 busy,
  output logic                 sat_flag,
  input  logic                 sat_clr
);

  localparam int LW = 4*W;

  function automatic logic [8*W-1:0] ident_f();
    logic [8*W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (IDENT_ONES[k]) r[k*W +: W] = W'(2**FRAC);
    return r;
  endfunction

  localparam logic [8*W-1:0] IDENT = ident_f();

  state_e         state_q;
  logic           busy_q, sat_q;
  logic [3:0]     v_q;
  logic [8*W-1:0] shadow_q, active_q;
  logic [N_PES-1:0] lane_sat;
  logic           en, accept;

  assign en       = !v_q[3] || m_ready;
  assign s_ready  = en && (state_q == ST_RUN) && !rst;
  assign accept   = s_valid && s_ready;
  assign m_valid  = v_q[3];
  assign busy     = busy_q;
  assign sat_flag = sat_q;

  for (genvar g = 0; g < N_PES; g++) begin : g_lane
    qpe_lane #(.W(W), .FRAC(FRAC)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .psi_i  (s_data[g*LW +: LW]),
      .coef_i (active_q),
      .psi_o  (m_data[g*LW +: LW]),
      .sat_o  (lane_sat[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      v_q      <= '0;
      shadow_q <= IDENT;
      active_q <= IDENT;
    end else begin
      if (en) v_q <= {v_q[2:0], accept};
      if (coef_we) shadow_q[int'(coef_addr)*W +: W] <= coef_wdata;
      // A clamp landing in the output register this cycle beats a clear.
      sat_q <= (en && v_q[2] && |lane_sat) || (sat_q && !sat_clr);
      case (state_q)
        ST_RUN: begin
          if (coef_commit) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (v_q == 4'b0000) state_q <= ST_SWAP;
        end
        ST_SWAP: begin
          active_q <= shadow_q;
          state_q  <= ST_RUN;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
